// File: rtl/neuron_mac_sequencer.sv
// Control sequencer for a CORDIC-based neuron MAC: walks the input/weight pairs,
// iterates each product until the residual converges, then accumulates it.
module neuron_mac_sequencer #(
    parameter int N_INPUTS = 4,
    parameter int ITER_MAX = 7,
    parameter int ZW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [ZW-1:0] zn,
    output logic [3:0]    in_addr,
    output logic          mac_load,
    output logic          mac_en,
    output logic [2:0]    iter,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          busy,
    output logic          done
);
    localparam logic [3:0] LAST_ADDR = 4'(N_INPUTS - 1);
    localparam logic [2:0] ITER_LIM  = 3'(ITER_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_ACC,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] in_addr_q, in_addr_d;
    logic [2:0] iter_q, iter_d;
    logic       conv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_addr_q <= '0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            in_addr_q <= in_addr_d;
            iter_q    <= iter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_addr_d = in_addr_q;
        iter_d    = iter_q;
        mac_load  = 1'b0;
        mac_en    = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        done      = 1'b0;
        conv      = (zn == '0) || (iter_q == ITER_LIM);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_LOAD;
                    in_addr_d = '0;
                    iter_d    = '0;
                end
            end
            S_LOAD: begin
                mac_load = 1'b1;
                acc_clr  = (in_addr_q == '0);
                state_d  = S_ITER;
            end
            S_ITER: begin
                if (!conv) begin
                    mac_en = 1'b1;
                    iter_d = iter_q + 3'd1;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_en = 1'b1;
                if (in_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_LOAD;
                    in_addr_d = in_addr_q + 4'd1;
                    iter_d    = '0;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Cancel freezes the counters where they stood; the next start reloads them.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            in_addr_d = in_addr_q;
            iter_d    = iter_q;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign in_addr = in_addr_q;
    assign iter    = iter_q;
endmodule
